// File: rtl/int_to_fp8.sv
`default_nettype none
// ============================================================================
// Module   : int_to_fp8
// Brief    : Sequential 8-bit signed integer to 8-bit float (S/E3/F4, no bias)
//            converter. Define INT_TO_FP8_ROUND_NEAREST_EN for round-half-even
//            packing; the default build truncates toward zero.
// Revision : 1.0 - initial release
// ============================================================================
module int_to_fp8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] op,
    output logic       ready,
    output logic       done,
    output logic [7:0] res,
    output logic       zero,
    output logic       inexact
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_PACK = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_sign;
    logic [7:0]  r_mag;
    logic [2:0]  r_exp;
    logic [7:0]  r_res;
    logic        r_done;
    logic        r_zero;
    logic        r_inexact;

    logic [7:0]  w_abs;
    logic [3:0]  w_frac;
    logic [2:0]  w_exp_pk;

    // Two's-complement negate of -128 wraps to 8'h80, which is exactly |op|.
    assign w_abs = op[7] ? (~op + 8'd1) : op;

`ifdef INT_TO_FP8_ROUND_NEAREST_EN
    logic        w_round_up;
    logic [4:0]  w_frac_sum;

    always_comb begin
        w_round_up = r_mag[2] & ((|r_mag[1:0]) | r_mag[3]);
        w_frac_sum = {1'b0, r_mag[6:3]} + {4'b0000, w_round_up};
        w_frac     = w_frac_sum[3:0];
        // A carry out of F only happens for exp<=6, so this cannot wrap.
        w_exp_pk   = r_exp + {2'b00, w_frac_sum[4]};
    end
`else
    always_comb begin
        w_frac   = r_mag[6:3];
        w_exp_pk = r_exp;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_sign    <= 1'b0;
            r_mag     <= 8'h00;
            r_exp     <= 3'd0;
            r_res     <= 8'h00;
            r_done    <= 1'b0;
            r_zero    <= 1'b0;
            r_inexact <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sign  <= op[7];
                        r_mag   <= w_abs;
                        r_exp   <= 3'd7;
                        r_state <= (op == 8'h00) ? ST_PACK : ST_NORM;
                    end
                end
                ST_NORM: begin
                    if (r_mag[7]) begin
                        r_state <= ST_PACK;
                    end else begin
                        r_mag <= {r_mag[6:0], 1'b0};
                        r_exp <= r_exp - 3'd1;
                    end
                end
                ST_PACK: begin
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                    // A nonzero input is always normalised here, so mag==0 means op==0.
                    if (r_mag == 8'h00) begin
                        r_res     <= 8'h00;
                        r_zero    <= 1'b1;
                        r_inexact <= 1'b0;
                    end else begin
                        r_res     <= {r_sign, w_exp_pk, w_frac};
                        r_zero    <= 1'b0;
                        r_inexact <= |r_mag[2:0];
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ready   = (r_state == ST_IDLE);
    assign done    = r_done;
    assign res     = r_res;
    assign zero    = r_zero;
    assign inexact = r_inexact;

endmodule
`default_nettype wire

// File: tb/tb_int_to_fp8.sv
`default_nettype none
// ============================================================================
// Module   : tb_int_to_fp8
// Brief    : Scoreboard bench for int_to_fp8 with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_int_to_fp8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] op    = 8'h00;
    wire        ready;
    wire        done;
    wire        zero;
    wire        inexact;
    wire  [7:0] res;

    int_to_fp8 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .ready   (ready),
        .done    (done),
        .res     (res),
        .zero    (zero),
        .inexact (inexact)
    );

    always #5 clk = ~clk;

`ifdef INT_TO_FP8_ROUND_NEAREST_EN
    localparam bit RN = 1'b1;
`else
    localparam bit RN = 1'b0;
`endif

    typedef struct {
        logic [7:0] res;
        logic       zero;
        logic       inexact;
        int         cyc;
    } exp_t;

    exp_t sbq[$];
    int   cycle = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic void chk(input string nm, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, expv, cycle);
        end
    endfunction

    // Monitor: pops one expectation per done pulse.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && done) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done with res=0x%0h, expected no done", res);
            end else begin
                e = sbq.pop_front();
                chk("res",     int'(res),     int'(e.res));
                chk("zero",    int'(zero),    int'(e.zero));
                chk("inexact", int'(inexact), int'(e.inexact));
                chk("latency_cycle", cycle, e.cyc);
            end
        end
    end

    task automatic convert(input logic [7:0] v, input logic [7:0] er, input logic ez,
                           input logic ei, input int lat, input bit hold, input int pulse_at);
        exp_t e;
        int   bound;
        bound = 0;
        while (!ready && bound < 20) begin
            @(negedge clk);
            bound++;
        end
        if (!ready) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_timeout: got ready=0, expected 1 for op=0x%0h", v);
        end
        e.res     = er;
        e.zero    = ez;
        e.inexact = ei;
        e.cyc     = cycle + 1 + lat;
        sbq.push_back(e);
        start = 1'b1;
        op    = v;
        @(negedge clk);
        if (!hold) start = 1'b0;
        op = ~v;
        for (int i = 0; i < 20 && sbq.size() != 0; i++) begin
            if (i == pulse_at) begin
                start = 1'b1;
                op    = 8'h05;
            end else if (!hold) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (sbq.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: got no done, expected done for op=0x%0h", v);
            sbq.delete();
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready",   int'(ready),   1);
        chk("rst_done",    int'(done),    0);
        chk("rst_res",     int'(res),     0);
        chk("rst_zero",    int'(zero),    0);
        chk("rst_inexact", int'(inexact), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Abort a long conversion with reset; no done may appear.
        start = 1'b1;
        op    = 8'd1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("busy_ready", int'(ready), 0);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", int'(ready), 1);
        chk("abort_res",   int'(res),   0);
        chk("abort_done",  int'(done),  0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);

        // Directed vectors, issued back-to-back (start on the edge after done).
        convert(8'd100,  8'h69, 1'b0, 1'b0, 3, 1'b0, -1);
        convert(8'h9C,   8'hE9, 1'b0, 1'b0, 3, 1'b0, -1);  // -100
        convert(8'h80,   8'hF0, 1'b0, 1'b0, 2, 1'b0, -1);  // -128
        convert(8'd1,    8'h00, 1'b0, 1'b0, 9, 1'b0, -1);
        convert(8'd0,    8'h00, 1'b1, 1'b0, 1, 1'b0, -1);
        convert(8'd127,  RN ? 8'h70 : 8'h6F, 1'b0, 1'b1, 3, 1'b0, -1);
        convert(8'd51,   RN ? 8'h5A : 8'h59, 1'b0, 1'b1, 4, 1'b0, -1);
        convert(8'd49,   8'h58, 1'b0, 1'b1, 4, 1'b0, -1);
        convert(8'd43,   RN ? 8'h56 : 8'h55, 1'b0, 1'b1, 4, 1'b0, -1);
        convert(8'd125,  8'h6F, 1'b0, 1'b1, 3, 1'b0, -1);
        convert(8'd16,   8'h40, 1'b0, 1'b0, 5, 1'b0, -1);
        convert(8'hFF,   8'h80, 1'b0, 1'b0, 9, 1'b0, -1);  // -1

        // Results hold through idle.
        repeat (3) @(negedge clk);
        chk("hold_res",  int'(res),  8'h80);
        chk("hold_done", int'(done), 0);

        // start held high across a whole conversion.
        convert(8'd100, 8'h69, 1'b0, 1'b0, 3, 1'b1, -1);
        repeat (4) @(negedge clk);

        // Second start pulsed mid-NORM must be ignored.
        convert(8'd1, 8'h00, 1'b0, 1'b0, 9, 1'b0, 2);
        repeat (12) @(negedge clk);
        chk("final_ready", int'(ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL global_timeout: got no finish, expected end of test");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
